// File: rtl/multdiv_pkg.sv
// Shared types and rstatus codes for the mult/div issue controller.
// Optional watchdog is enabled with MULTDIV_TIMEOUT_EN.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        WB
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        is_div;
        logic [4:0]  rd;
    } op_t;

    localparam logic [4:0]  RSTATUS_REG     = 5'd30;
    localparam logic [31:0] RSTATUS_MULT    = 32'd4;
    localparam logic [31:0] RSTATUS_DIV     = 32'd5;
    localparam logic [31:0] RSTATUS_TIMEOUT = 32'd6;

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Pipeline-side handshake bundle: issue request in, writeback request out.
// Master is the execute/writeback side, slave is the issue controller.
interface multdiv_issue_ctrl_if;

    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_A;
    logic [31:0] issue_B;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        flush;
    logic        stall;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    modport master (
        output issue_valid, issue_is_div, issue_A, issue_B, issue_rd,
        output flush, wb_ready,
        input  issue_ready, stall, wb_valid, wb_rd, wb_data, wb_exception
    );

    modport slave (
        input  issue_valid, issue_is_div, issue_A, issue_B, issue_rd,
        input  flush, wb_ready,
        output issue_ready, stall, wb_valid, wb_rd, wb_data, wb_exception
    );

endinterface

// File: rtl/multdiv_watchdog.sv
// Saturating BUSY-cycle counter; expired marks the LIMIT-th enabled cycle.
// Only instantiated when MULTDIV_TIMEOUT_EN is defined.
module multdiv_watchdog #(
    parameter int LIMIT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != W'(LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // count holds completed cycles, so the current one is count+1
    assign expired = enable && (count >= W'(LIMIT - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the iterative mult/div unit (IDLE/START/BUSY/WB).
// Define MULTDIV_TIMEOUT_EN to add a BUSY watchdog reporting rstatus 6.
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    multdiv_issue_ctrl_if.slave pipe,
    output logic [31:0]         data_operandA,
    output logic [31:0]         data_operandB,
    output logic                ctrl_MULT,
    output logic                ctrl_DIV,
    output logic                is_div,
    input  logic [31:0]         data_result,
    input  logic                data_exception,
    input  logic                data_resultRDY
);

    state_t     state;
    op_t        op;
    logic [4:0] rd;
    logic       expired;

    assign op = '{
        a:      pipe.issue_A,
        b:      pipe.issue_B,
        is_div: pipe.issue_is_div,
        rd:     pipe.issue_rd
    };

`ifdef MULTDIV_TIMEOUT_EN
    multdiv_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state == START),
        .enable  (state == BUSY),
        .expired (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    // reset_n gate keeps issue_ready low while reset is held
    assign pipe.issue_ready = reset_n && (state == IDLE);
    assign pipe.stall       = (state != IDLE);
    assign pipe.wb_valid    = (state == WB);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            data_operandA     <= '0;
            data_operandB     <= '0;
            is_div            <= 1'b0;
            rd                <= '0;
            ctrl_MULT         <= 1'b0;
            ctrl_DIV          <= 1'b0;
            pipe.wb_rd        <= '0;
            pipe.wb_data      <= '0;
            pipe.wb_exception <= 1'b0;
        end else begin
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pipe.issue_valid && !pipe.flush) begin
                        data_operandA <= op.a;
                        data_operandB <= op.b;
                        is_div        <= op.is_div;
                        rd            <= op.rd;
                        ctrl_MULT     <= !op.is_div;
                        ctrl_DIV      <= op.is_div;
                        state         <= START;
                    end
                end
                START: begin
                    state <= pipe.flush ? IDLE : BUSY;
                end
                BUSY: begin
                    if (pipe.flush) begin
                        state <= IDLE;
                    end else if (data_resultRDY) begin
                        state             <= WB;
                        pipe.wb_exception <= data_exception;
                        if (data_exception) begin
                            pipe.wb_rd   <= RSTATUS_REG;
                            pipe.wb_data <= is_div ? RSTATUS_DIV
                                                   : RSTATUS_MULT;
                        end else begin
                            pipe.wb_rd   <= rd;
                            pipe.wb_data <= data_result;
                        end
                    end else if (expired) begin
                        state             <= WB;
                        pipe.wb_exception <= 1'b1;
                        pipe.wb_rd        <= RSTATUS_REG;
                        pipe.wb_data      <= RSTATUS_TIMEOUT;
                    end
                end
                WB: begin
                    if (pipe.flush || pipe.wb_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Randomized bench for multdiv_issue_ctrl with a per-op schedule model.
// Timeout cases are modelled when MULTDIV_TIMEOUT_EN is defined.
module tb_multdiv_issue_ctrl;

    localparam int TMO = 15;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        is_div;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errs   = 0;

    multdiv_issue_ctrl_if pipe();

    multdiv_issue_ctrl #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pipe           (pipe),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .is_div         (is_div),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit mul_ovf(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p != longint'($signed(p[31:0]));
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, ":opA"}, data_operandA, 0);
        chk({tag, ":opB"}, data_operandB, 0);
        chk({tag, ":mult"}, ctrl_MULT, 0);
        chk({tag, ":div"}, ctrl_DIV, 0);
        chk({tag, ":isdiv"}, is_div, 0);
        chk({tag, ":stall"}, pipe.stall, 0);
        chk({tag, ":rdy"}, pipe.issue_ready, 0);
        chk({tag, ":wbv"}, pipe.wb_valid, 0);
        chk({tag, ":wbrd"}, pipe.wb_rd, 0);
        chk({tag, ":wbd"}, pipe.wb_data, 0);
        chk({tag, ":wbx"}, pipe.wb_exception, 0);
    endtask

    // Cycle 0 = accept. rdy_c: cycle the unit raises RDY.
    // wbd: WB cycles before wb_ready. flush_c: 0 = none.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic dv, input logic [4:0] rd,
                          input int rdy_c, input int wbd, input int flush_c);
        logic [31:0] res, exp_data;
        logic [4:0]  exp_rd;
        bit          exc, to, idle, wbv;
        int          wb_first, last_c;
        string       t;
        res = dv ? ((b == 0) ? 32'd0 : a / b) : a * b;
        exc = dv ? (b == 0) : mul_ovf(a, b);
        to  = 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
        if (rdy_c > TMO + 1) to = 1'b1;
`endif
        wb_first = to ? TMO + 2 : rdy_c + 1;
        if (to) begin
            exp_rd = 5'd30; exp_data = 32'd6;
        end else if (exc) begin
            exp_rd = 5'd30; exp_data = dv ? 32'd5 : 32'd4;
        end else begin
            exp_rd = rd; exp_data = res;
        end
        last_c = (flush_c > 0) ? flush_c : wb_first + wbd;
        for (int c = 0; c <= last_c + 1; c++) begin
            if (c == 0) begin
                pipe.issue_valid  = 1'b1;
                pipe.issue_A      = a;
                pipe.issue_B      = b;
                pipe.issue_is_div = dv;
                pipe.issue_rd     = rd;
            end else begin
                pipe.issue_valid  = (c <= last_c) ? 1'($urandom) : 1'b0;
                pipe.issue_A      = $urandom;
                pipe.issue_B      = $urandom;
                pipe.issue_is_div = 1'($urandom);
                pipe.issue_rd     = 5'($urandom);
            end
            pipe.flush = (flush_c > 0 && c == flush_c);
            if (c == rdy_c && !to) begin
                data_resultRDY = 1'b1;
                data_result    = res;
                data_exception = exc;
            end else begin
                data_resultRDY = (c < 2 || c >= wb_first) ? 1'($urandom) : 1'b0;
                data_result    = $urandom;
                data_exception = 1'($urandom);
            end
            if (c > last_c)
                pipe.wb_ready = 1'b0;
            else if (c < wb_first)
                pipe.wb_ready = 1'($urandom);
            else if (c < last_c)
                pipe.wb_ready = 1'b0;
            else
                pipe.wb_ready = (flush_c > 0) ? 1'($urandom) : 1'b1;
            @(negedge clock);
            t    = $sformatf("c%0d", c);
            idle = (c == 0 || c > last_c);
            wbv  = (c >= wb_first && c <= last_c);
            chk({t, ":stall"}, pipe.stall, !idle);
            chk({t, ":issue_ready"}, pipe.issue_ready, idle);
            chk({t, ":ctrl_MULT"}, ctrl_MULT, (c == 1 && !dv));
            chk({t, ":ctrl_DIV"}, ctrl_DIV, (c == 1 && dv));
            chk({t, ":wb_valid"}, pipe.wb_valid, wbv);
            if (!idle) begin
                chk({t, ":opA"}, data_operandA, a);
                chk({t, ":opB"}, data_operandB, b);
                chk({t, ":is_div"}, is_div, dv);
            end
            if (wbv) begin
                chk({t, ":wb_rd"}, pipe.wb_rd, exp_rd);
                chk({t, ":wb_data"}, pipe.wb_data, exp_data);
                chk({t, ":wb_exc"}, pipe.wb_exception, (to || exc));
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int rdy_c, wbd, fl;
        logic dv;
        logic [31:0] a, b;
        reset_n           = 1'b0;
        pipe.issue_valid  = 1'b0;
        pipe.issue_is_div = 1'b0;
        pipe.issue_A      = '0;
        pipe.issue_B      = '0;
        pipe.issue_rd     = '0;
        pipe.flush        = 1'b0;
        pipe.wb_ready     = 1'b0;
        data_result       = '0;
        data_exception    = 1'b0;
        data_resultRDY    = 1'b0;
        #1 all_zero("reset");
        #11 reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_op(32'd7, 32'd6, 1'b0, 5'd3, 6, 0, 0);
        run_op(32'd100, 32'd7, 1'b1, 5'd9, 8, 0, 0);
        run_op(32'd5, 32'd0, 1'b1, 5'd1, 8, 0, 0);
        run_op(32'h4000_0000, 32'd4, 1'b0, 5'd2, 6, 0, 0);
        run_op(32'd9, 32'd3, 1'b1, 5'd12, 8, 5, 0);
        run_op(32'd11, 32'd13, 1'b0, 5'd4, 6, 0, 6);
        run_op(32'd20, 32'd4, 1'b1, 5'd5, 8, 3, 10);
        run_op(32'd21, 32'd2, 1'b0, 5'd6, 16, 0, 0);
        run_op(32'd33, 32'd3, 1'b1, 5'd7, 40, 1, 0);

        // flush together with issue_valid in IDLE blocks the accept
        pipe.issue_valid = 1'b1;
        pipe.flush       = 1'b1;
        @(negedge clock);
        chk("flush_idle:ready", pipe.issue_ready, 1);
        @(posedge clock);
        #1;
        pipe.issue_valid = 1'b0;
        pipe.flush       = 1'b0;
        @(negedge clock);
        chk("flush_idle:stall", pipe.stall, 0);
        chk("flush_idle:ctrl", ctrl_MULT | ctrl_DIV, 0);
        @(posedge clock);
        #1;

        // async reset while BUSY drops the op
        pipe.issue_valid  = 1'b1;
        pipe.issue_A      = 32'd55;
        pipe.issue_B      = 32'd66;
        pipe.issue_is_div = 1'b1;
        pipe.issue_rd     = 5'd8;
        @(posedge clock);
        #1 pipe.issue_valid = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b0;
        #1 all_zero("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("after_reset:ready", pipe.issue_ready, 1);
        chk("after_reset:stall", pipe.stall, 0);
        @(posedge clock);
        #1;

        for (int n = 0; n < 40; n++) begin
            dv    = 1'($urandom);
            a     = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 999));
            b     = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 99));
            rdy_c = $urandom_range(2, 20);
            wbd   = $urandom_range(0, 4);
            fl    = 0;
            if ($urandom_range(0, 7) == 0)
                fl = $urandom_range(1, rdy_c + 1);
            run_op(a, b, dv, 5'($urandom), rdy_c, wbd, fl);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_issue_ctrl.md
# multdiv_issue_ctrl

Initiator-side controller for the iterative multiply/divide unit. It accepts a mult/div op from the execute stage, latches the operands and destination, and issues a one-cycle `ctrl_MULT`/`ctrl_DIV` pulse with operands held stable. It waits for `data_resultRDY`, then presents a writeback request (result, or rstatus code on exception) while stalling the pipeline until the writeback is accepted.

## Interface
- `TIMEOUT_CYCLES`, default 15: max BUSY cycles before the watchdog fires (only with the watchdog macro).
- `clock  in  1`: single clock, rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `issue_valid  in  1`: execute stage presents a mult/div op.
- `issue_is_div  in  1`: 1 = divide, 0 = multiply.
- `issue_A`, `issue_B`  in  32 each: operands.
- `issue_rd  in  5`: destination register.
- `issue_ready  out  1`: high only in IDLE.
- `flush  in  1`: synchronous abort of any in-flight op.
- `data_operandA`, `data_operandB`  out  32 each: latched operands to the unit.
- `ctrl_MULT`, `ctrl_DIV`  out  1 each: one-cycle start pulses.
- `is_div  out  1`: latched op type, held from START through WB.
- `data_result  in  32`: unit result.
- `data_exception  in  1`: unit exception (overflow or div-by-zero).
- `data_resultRDY  in  1`: unit ready; may pulse spuriously outside an op.
- `stall  out  1`: high whenever state ≠ IDLE.
- `wb_valid  out  1`: writeback request.
- `wb_ready  in  1`: writeback accepted.
- `wb_rd  out  5`: writeback destination.
- `wb_data  out  32`: writeback value.
- `wb_exception  out  1`: writeback carries an rstatus code.

## Operation
- States: IDLE, START, BUSY, WB.
- **IDLE:**
  - If `issue_valid && !flush`, latch A, B, `is_div` and rd, then go to START.
  - Otherwise stay in IDLE.
- **START (exactly one cycle):**
  - `ctrl_DIV = is_div`, `ctrl_MULT = !is_div`.
  - Go to BUSY.
- **BUSY:**
  - `data_resultRDY` is sampled only in this state. RDY in IDLE, START or WB is ignored.
  - On RDY, capture the write-back value and go to WB:
    - no exception: `wb_rd = latched rd`, `wb_data = data_result`, `wb_exception = 0`;
    - `data_exception`: `wb_rd = 30`, `wb_data` = 4 for mult or 5 for div, `wb_exception = 1`.
- **WB:**
  - `wb_valid = 1`; `wb_rd`, `wb_data` and `wb_exception` are held stable.
  - On `wb_ready`, go to IDLE.
- Operands and `is_div` stay constant from START until the next accept. The unit is combinational on them.
- **flush:** in START, BUSY or WB, go to IDLE next cycle and discard the result. `flush` beats a same-cycle RDY, `wb_ready` or `issue_valid`.
- **Async reset:** all state clears to IDLE; every output is 0, including `data_operandA/B`, `wb_*`, ctrl pulses and `stall`. Reset mid-op drops the op silently.
- A new op is accepted no earlier than the cycle after WB completes. There is no back-to-back overlap.

## Timing
- Cycle 0: IDLE with `issue_valid`; accepted on this edge.
- Cycle 1: START; ctrl pulse high. `stall` is high from cycle 1.
- Cycle 2 onward: BUSY.
- With the standard unit (counter reset by the pulse):
  - mult: RDY in cycle 6, `wb_valid` from cycle 7;
  - div: RDY in cycle 8, `wb_valid` from cycle 9.
- `wb_ready` in the same cycle `wb_valid` rises completes writeback. IDLE follows in the next cycle and `stall` drops then.
- `issue_ready` is combinational from state only, with no path from `issue_valid`.
- All outputs are registered or decoded from state, with no input→output combinational paths.

## Configuration
- Macro: `MULTDIV_TIMEOUT_EN`.
- **Defined:**
  - A watchdog counts BUSY cycles, clearing on entry to BUSY.
  - When the count reaches `TIMEOUT_CYCLES` without RDY, go to WB with `wb_rd = 30`, `wb_data = 6`, `wb_exception = 1`.
  - RDY in the same cycle as the timeout wins.
- **Undefined:** no counter, no code 6; BUSY waits indefinitely. `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `multdiv_pkg` holds:
  - the state enum (IDLE/START/BUSY/WB);
  - `RSTATUS_REG = 30`;
  - `RSTATUS_MULT = 4`, `RSTATUS_DIV = 5`, `RSTATUS_TIMEOUT = 6`.
- One sub-module, `multdiv_watchdog`: a saturating counter with clear/enable and a `expired` output, instantiated only under `MULTDIV_TIMEOUT_EN`.

## Test plan
- Mult 7×6, rd=3, `wb_ready` tied high -> `ctrl_MULT` pulse in cycle 1 only; `wb_valid` in cycle 7 with rd=3, data=42; `stall` high in cycles 1–7.
- Div 100/7, rd=9 -> `ctrl_DIV` pulse in cycle 1; `wb_valid` in cycle 9 with rd=9, data=14; `is_div=1` throughout.
- Div 5/0 -> wb rd=30, data=5, `wb_exception=1`. Mult 0x40000000×4 (overflow) -> rd=30, data=4.
- Hold `wb_ready` low for 5 cycles -> `wb_valid`/`wb_data` stable; `issue_valid` ignored (`issue_ready=0`); IDLE one cycle after `wb_ready`.
- Spurious RDY pulses in IDLE and START are ignored. `flush` in BUSY concurrent with RDY -> IDLE next cycle, no `wb_valid`. Deassert `reset_n` mid-BUSY -> all outputs 0 immediately.
- With `MULTDIV_TIMEOUT_EN` and RDY never asserted -> after 15 BUSY cycles, wb rd=30, data=6, `wb_exception=1`.
